// File: rtl/vsm_phase_sequencer.sv
// ---------------------------------------------------------------------------
// vsm_phase_sequencer
//
// Control sequencer for the VSM 4-bit microprocessor. It sits directly
// downstream of the 5-phase ring counter and owns the program counter,
// instruction register and run state. Memory address/strobes and the
// accumulator/ALU control strobes are decoded combinationally from the
// state, the current phase and the instruction register.
//
// Instruction timing (one instruction per ring-counter revolution):
//   Phase0/1 : fetch from PC (IR/PC update at the Phase1 edge)
//   Phase2/3 : operand access, accumulator/output load in Phase3
//   Phase4   : store strobe, branch / halt at the closing edge
//
// Ports:
//   Phase_Count      clock shared with the ring counter (rising edge)
//   invClear         synchronous active-low reset
//   Phase0..Phase4   one-hot phase strobes from the ring counter
//   Run              start request (sampled on a Phase0 edge in IDLE)
//   Step             single-step continue (only with VSM_SINGLE_STEP_EN)
//   MemData          {opcode, operand} read data
//   AccZero          accumulator-is-zero flag from the datapath
//   MemAddr          memory address
//   MemRd / MemWr    memory read / write strobes
//   AccLoad          accumulator load enable
//   AluSub           ALU subtract select
//   AluPass          ALU passes the memory operand (LDA)
//   OutLoad          output-port register load (OUT)
//   Halted           sequencer is halted
//   PhaseErr         a phase-encoding fault was detected
//   PC               current program counter
//
// Build option:
//   VSM_SINGLE_STEP_EN  adds the Step input and a PAUSE state that stops
//                       after every completed non-HLT instruction.
// ---------------------------------------------------------------------------
module vsm_phase_sequencer #(
  parameter int unsigned         PC_WIDTH = 4,
  parameter int unsigned         OP_WIDTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         Phase_Count,
  input  logic                         invClear,
  input  logic                         Phase0,
  input  logic                         Phase1,
  input  logic                         Phase2,
  input  logic                         Phase3,
  input  logic                         Phase4,
  input  logic                         Run,
`ifdef VSM_SINGLE_STEP_EN
  input  logic                         Step,
`endif
  input  logic [OP_WIDTH+PC_WIDTH-1:0] MemData,
  input  logic                         AccZero,
  output logic [PC_WIDTH-1:0]          MemAddr,
  output logic                         MemRd,
  output logic                         MemWr,
  output logic                         AccLoad,
  output logic                         AluSub,
  output logic                         AluPass,
  output logic                         OutLoad,
  output logic                         Halted,
  output logic                         PhaseErr,
  output logic [PC_WIDTH-1:0]          PC
);

  // ARM is an internal sub-state of "running": it covers the remainder of
  // the revolution after the start edge so that execution begins on the
  // next Phase0. Externally it is indistinguishable from RUN except that
  // no strobes are issued.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_HALT,
    S_FAULT
`ifdef VSM_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_OUT = 4'h7,
    OP_HLT = 4'hF
  } opcode_e;

  state_e                        state_q, state_d;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  logic [OP_WIDTH+PC_WIDTH-1:0]  ir_q, ir_d;

  logic [OP_WIDTH-1:0]           opc;
  logic [PC_WIDTH-1:0]           operand;
  logic [2:0]                    phase_cnt;
  logic                          phase_ok;
  logic                          exec;
  logic                          is_lda, is_sta, is_add, is_sub;
  logic                          is_jmp, is_jz, is_out, is_hlt;

  // -------------------------------------------------------------------------
  // Instruction decode and phase sanity check
  // -------------------------------------------------------------------------
  always_comb begin
    opc     = ir_q[OP_WIDTH+PC_WIDTH-1 -: OP_WIDTH];
    operand = ir_q[PC_WIDTH-1:0];

    is_lda  = (opc == OP_WIDTH'(OP_LDA));
    is_sta  = (opc == OP_WIDTH'(OP_STA));
    is_add  = (opc == OP_WIDTH'(OP_ADD));
    is_sub  = (opc == OP_WIDTH'(OP_SUB));
    is_jmp  = (opc == OP_WIDTH'(OP_JMP));
    is_jz   = (opc == OP_WIDTH'(OP_JZ));
    is_out  = (opc == OP_WIDTH'(OP_OUT));
    is_hlt  = (opc == OP_WIDTH'(OP_HLT));

    phase_cnt = 3'(Phase0) + 3'(Phase1) + 3'(Phase2) + 3'(Phase3) + 3'(Phase4);
    phase_ok  = (phase_cnt == 3'd1);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;

    // A bad phase encoding overrides everything and freezes PC/IR.
    if (!phase_ok) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Run && Phase0) state_d = S_ARM;
        end

        S_ARM: begin
          if (Phase4) state_d = S_RUN;
        end

        S_RUN: begin
          if (Phase1) begin
            ir_d = MemData;
            pc_d = pc_q + PC_WIDTH'(1);
          end
          if (Phase4) begin
            if (is_jmp || (is_jz && AccZero)) pc_d = operand;
            if (is_hlt) begin
              state_d = S_HALT;
            end
`ifdef VSM_SINGLE_STEP_EN
            else begin
              state_d = S_PAUSE;
            end
`endif
          end
        end

`ifdef VSM_SINGLE_STEP_EN
        S_PAUSE: begin
          if (Step && Phase0) state_d = S_ARM;
        end
`endif

        default: begin
          // HALT and FAULT are left only by reset.
          state_d = state_q;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Phase_Count) begin
    if (!invClear) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    MemAddr = pc_q;
    MemRd   = 1'b0;
    MemWr   = 1'b0;
    AccLoad = 1'b0;
    AluSub  = 1'b0;
    AluPass = 1'b0;
    OutLoad = 1'b0;

    // Strobes are suppressed during reset so a store in flight is aborted
    // cleanly, and on an illegal phase pattern so nothing fires while the
    // fault is being latched.
    exec = invClear && phase_ok && (state_q == S_RUN);

    if (exec) begin
      if (Phase0 || Phase1) begin
        MemRd = 1'b1;
      end
      if (Phase2 || Phase3) begin
        MemAddr = operand;
        MemRd   = is_lda || is_add || is_sub;
      end
      if (Phase3) begin
        AccLoad = is_lda || is_add || is_sub;
        AluPass = is_lda;
        AluSub  = is_sub;
        OutLoad = is_out;
      end
      if (Phase4 && is_sta) begin
        MemAddr = operand;
        MemWr   = 1'b1;
      end
    end

    Halted   = (state_q == S_HALT);
    PhaseErr = (state_q == S_FAULT);
    PC       = pc_q;
  end

endmodule

// File: tb/tb_vsm_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vsm_phase_sequencer
//
// Directed bench for vsm_phase_sequencer. The bench plays the role of the
// ring counter (one-hot Phase0..Phase4 advancing every clock) and of a
// 16-entry program memory read through MemAddr.
// ---------------------------------------------------------------------------
module tb_vsm_phase_sequencer;

  logic       Phase_Count = 1'b0;
  logic       invClear;
  logic       Phase0, Phase1, Phase2, Phase3, Phase4;
  logic       Run;
  logic       Step;
  logic [7:0] MemData;
  logic       AccZero;
  logic [3:0] MemAddr;
  logic       MemRd, MemWr, AccLoad, AluSub, AluPass, OutLoad;
  logic       Halted, PhaseErr;
  logic [3:0] PC;

  logic [7:0] mem [16];
  logic [5:0] strb;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned ph;

  vsm_phase_sequencer #(
    .PC_WIDTH (4),
    .OP_WIDTH (4),
    .RESET_PC (4'h0)
  ) dut (
    .Phase_Count (Phase_Count),
    .invClear    (invClear),
    .Phase0      (Phase0),
    .Phase1      (Phase1),
    .Phase2      (Phase2),
    .Phase3      (Phase3),
    .Phase4      (Phase4),
    .Run         (Run),
`ifdef VSM_SINGLE_STEP_EN
    .Step        (Step),
`endif
    .MemData     (MemData),
    .AccZero     (AccZero),
    .MemAddr     (MemAddr),
    .MemRd       (MemRd),
    .MemWr       (MemWr),
    .AccLoad     (AccLoad),
    .AluSub      (AluSub),
    .AluPass     (AluPass),
    .OutLoad     (OutLoad),
    .Halted      (Halted),
    .PhaseErr    (PhaseErr),
    .PC          (PC)
  );

  always #5 Phase_Count = ~Phase_Count;

  always_comb MemData = mem[MemAddr];
  // {MemRd, MemWr, AccLoad, AluSub, AluPass, OutLoad}
  always_comb strb = {MemRd, MemWr, AccLoad, AluSub, AluPass, OutLoad};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_strb(input string tag, input logic [5:0] exp);
    check_eq(tag, 32'(strb), 32'(exp));
  endtask

  task automatic chk_addr(input string tag, input logic [3:0] exp);
    check_eq(tag, 32'(MemAddr), 32'(exp));
  endtask

  task automatic chk_pc(input string tag, input logic [3:0] exp);
    check_eq(tag, 32'(PC), 32'(exp));
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    check_eq(tag, 32'(got), 32'(exp));
  endtask

  task automatic drive_phase();
    {Phase4, Phase3, Phase2, Phase1, Phase0} = 5'b00001 << ph;
  endtask

  // One clock: ring counter advances just after the edge, checks follow.
  task automatic cyc();
    @(posedge Phase_Count);
    #1;
    ph = (ph + 1) % 5;
    drive_phase();
    #1;
  endtask

  task automatic run_to(input int unsigned p);
    for (int i = 0; i < 5 && ph != p; i++) cyc();
  endtask

  // From Phase0 of an instruction, run through its closing Phase4 edge.
  task automatic exec_instr();
    run_to(4);
    cyc();
  endtask

  task automatic do_reset();
    invClear = 1'b0;
    #1;
    chk_strb("rst_strb", 6'b000000);
    cyc();
    invClear = 1'b1;
    #1;
  endtask

  // Request start on a Phase0 edge; returns in Phase1 right after.
  task automatic start_run();
    Run = 1'b1;
    run_to(0);
    cyc();
    Run = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    invClear = 1'b0;
    Run      = 1'b0;
    Step     = 1'b0;
    AccZero  = 1'b0;
    ph       = 0;
    drive_phase();
    clear_mem();

    // ---- reset / start ----------------------------------------------------
    #2;
    chk_strb("init_rst_strb", 6'b000000);
    cyc();
    invClear = 1'b1;
    #1;
    chk_pc("rst_pc", 4'h0);
    chk_bit("rst_halted", Halted, 1'b0);
    chk_bit("rst_phaseerr", PhaseErr, 1'b0);
    chk_strb("rst_idle_strb", 6'b000000);

    // ---- LDA E / ADD D / STA C / HLT --------------------------------------
    mem[0] = 8'h1E; mem[1] = 8'h3D; mem[2] = 8'h2C; mem[3] = 8'hF0;
    mem[14] = 8'h03; mem[13] = 8'h04;
    start_run();
    chk_strb("start_no_exec", 6'b000000);
    run_to(0);
    chk_addr("i0_p0_addr", 4'h0);
    chk_strb("i0_p0_strb", 6'b100000);
    cyc();
    chk_strb("i0_p1_strb", 6'b100000);
    cyc();
    chk_pc("i0_p2_pc", 4'h1);
    chk_addr("i0_p2_addr", 4'hE);
    chk_strb("i0_p2_strb", 6'b100000);
    cyc();
    chk_strb("lda_p3_strb", 6'b101010);
    cyc();
    chk_strb("i0_p4_strb", 6'b000000);
    cyc();
    chk_addr("i1_p0_addr", 4'h1);
    run_to(2);
    chk_addr("i1_p2_addr", 4'hD);
    cyc();
    chk_strb("add_p3_strb", 6'b101000);
    run_to(0);
    chk_addr("i2_p0_addr", 4'h2);
    run_to(2);
    chk_strb("sta_p2_strb", 6'b000000);
    cyc();
    chk_strb("sta_p3_strb", 6'b000000);
    cyc();
    chk_strb("sta_p4_strb", 6'b010000);
    chk_addr("sta_p4_addr", 4'hC);
    cyc();
    chk_addr("i3_p0_addr", 4'h3);
    run_to(4);
    chk_bit("hlt_p4_halted", Halted, 1'b0);
    cyc();
    chk_bit("hlt_halted", Halted, 1'b1);
    chk_pc("hlt_pc", 4'h4);
    chk_strb("hlt_strb", 6'b000000);
    cyc();
    cyc();
    chk_bit("halt_hold", Halted, 1'b1);
    chk_pc("halt_hold_pc", 4'h4);
    chk_strb("halt_hold_strb", 6'b000000);

    // ---- reset in the middle of STA ----------------------------------------
    clear_mem();
    mem[0] = 8'h2C;
    do_reset();
    chk_bit("rst_clr_halted", Halted, 1'b0);
    start_run();
    run_to(0);
    run_to(4);
    chk_strb("abort_pre_strb", 6'b010000);
    invClear = 1'b0;
    #1;
    chk_strb("abort_strb", 6'b000000);
    cyc();
    invClear = 1'b1;
    #1;
    chk_pc("abort_pc", 4'h0);
    chk_bit("abort_halted", Halted, 1'b0);
    run_to(0);
    chk_strb("abort_idle_strb", 6'b000000);

    // ---- branches ----------------------------------------------------------
    clear_mem();
    mem[0] = 8'h6A;
    AccZero = 1'b1;
    do_reset();
    start_run();
    run_to(0);
    exec_instr();
    chk_pc("jz_taken_pc", 4'hA);
    chk_addr("jz_taken_fetch", 4'hA);

    AccZero = 1'b0;
    do_reset();
    start_run();
    run_to(0);
    exec_instr();
    chk_pc("jz_not_pc", 4'h1);

    mem[0] = 8'h55;
    do_reset();
    start_run();
    run_to(0);
    exec_instr();
    chk_pc("jmp_pc", 4'h5);
    chk_addr("jmp_fetch_addr", 4'h5);
    chk_strb("jmp_fetch_strb", 6'b100000);

    // ---- SUB / OUT / JMP F / PC wrap ---------------------------------------
    clear_mem();
    mem[0] = 8'h43; mem[1] = 8'h73; mem[2] = 8'h5F; mem[3] = 8'h03;
    mem[15] = 8'h00;
    do_reset();
    start_run();
    run_to(0);
    run_to(3);
    chk_strb("sub_p3_strb", 6'b101100);
    chk_addr("sub_p3_addr", 4'h3);
    run_to(0);
    run_to(3);
    chk_strb("out_p3_strb", 6'b000001);
    run_to(0);
    exec_instr();
    chk_pc("jmp_f_pc", 4'hF);
    chk_addr("fetch_f_addr", 4'hF);
    cyc();
    cyc();
    chk_pc("pc_wrap", 4'h0);

    // ---- phase faults ------------------------------------------------------
    clear_mem();
    mem[0] = 8'h1E;
    do_reset();
    start_run();
    run_to(0);
    cyc();
    Phase2 = 1'b1;
    #1;
    cyc();
    chk_bit("fault_set", PhaseErr, 1'b1);
    chk_strb("fault_strb", 6'b000000);
    run_to(0);
    chk_bit("fault_hold", PhaseErr, 1'b1);
    chk_strb("fault_hold_strb", 6'b000000);
    chk_bit("fault_not_halted", Halted, 1'b0);
    do_reset();
    chk_bit("fault_clr", PhaseErr, 1'b0);

    {Phase4, Phase3, Phase2, Phase1, Phase0} = 5'b00000;
    #1;
    cyc();
    chk_bit("nophase_fault", PhaseErr, 1'b1);
    do_reset();
    chk_bit("nophase_clr", PhaseErr, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
